// File: rtl/bank_xbar_arbiter.sv
// rtl/bank_xbar_arbiter.sv - per-bank crossbar arbiter with ingress priority, round-robin node grants and 2-entry egress FIFO
package bank_xbar_pkg;
  localparam int NODES_PER_BANK = 4;
  localparam int BANK_W = 4;
  localparam int Z_W = 2;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [Z_W-1:0]    z;
  } addr_t;

  typedef struct packed {
    addr_t             addr;
    logic [DATA_W-1:0] data;
  } pkt_t;
endpackage

module bank_xbar_arbiter
  import bank_xbar_pkg::*;
#(
  parameter int N = NODES_PER_BANK,
  parameter int BANK_ID = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     src_valid,
  input  pkt_t [N-1:0]     src_pkt,
  output logic [N-1:0]     src_ready,
  output logic [N-1:0]     dst_valid,
  output pkt_t [N-1:0]     dst_pkt,
  input  logic [N-1:0]     dst_ready,
  input  logic             rin_valid,
  output logic             rin_ready,
  input  pkt_t             rin_pkt,
  output logic             rout_valid,
  input  logic             rout_ready,
  output pkt_t             rout_pkt,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr, ptr_next;
  logic [N-1:0]     claimed;
  logic             egress_claimed;
  logic             fifo_space;
  logic             push, pop;
  pkt_t             push_pkt;
  pkt_t             mem [2];
  logic             head;
  logic [1:0]       count;
  logic             wr_addr;
  logic             conflict;

  // Explicit mod-N wrap; base and k are both below N so one subtract suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  assign rout_valid = (count != 2'd0);
  assign pop        = rout_valid && rout_ready;
  assign fifo_space = (count != 2'd2) || pop;
  assign rout_pkt   = rout_valid ? mem[head] : '0;

  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [Z_W-1:0]   z;
    claimed        = '0;
    egress_claimed = 1'b0;
    src_ready      = '0;
    dst_valid      = '0;
    dst_pkt        = '0;
    rin_ready      = 1'b0;
    push           = 1'b0;
    push_pkt       = '0;
    ptr_next       = ptr;
    idx            = '0;
    z              = '0;

    if (int'(rin_pkt.addr.z) < N) rin_ready = dst_ready[rin_pkt.addr.z];
    if (rin_valid && rin_ready) begin
      dst_valid[rin_pkt.addr.z] = 1'b1;
      dst_pkt[rin_pkt.addr.z]   = rin_pkt;
      claimed[rin_pkt.addr.z]   = 1'b1;
    end

    for (int k = 0; k < N; k++) begin
      idx = wrap_add(ptr, k);
      z   = src_pkt[idx].addr.z;
      if (src_valid[idx]) begin
        if (int'(src_pkt[idx].addr.bank) == BANK_ID) begin
          if (int'(z) < N && !claimed[z] && dst_ready[z]) begin
            dst_valid[z]   = 1'b1;
            dst_pkt[z]     = src_pkt[idx];
            claimed[z]     = 1'b1;
            src_ready[idx] = 1'b1;
            ptr_next       = wrap_add(idx, 1);
          end
        end else if (!egress_claimed && fifo_space) begin
          push           = 1'b1;
          push_pkt       = src_pkt[idx];
          egress_claimed = 1'b1;
          src_ready[idx] = 1'b1;
          ptr_next       = wrap_add(idx, 1);
        end
      end
    end
  end

  assign conflict = (|(src_valid & ~src_ready)) || (rin_valid && !rin_ready);

  // A push into a full FIFO reuses the slot being popped this cycle.
  assign wr_addr = head ^ (count == 2'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      head         <= 1'b0;
      count        <= 2'd0;
      mem[0]       <= '0;
      mem[1]       <= '0;
      conflict_cnt <= '0;
    end else begin
      ptr <= ptr_next;
      if (push) mem[wr_addr] <= push_pkt;
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (conflict && conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_xbar_arbiter.sv
// tb/tb_bank_xbar_arbiter.sv - directed-vector bench for bank_xbar_arbiter
module tb_bank_xbar_arbiter;
  import bank_xbar_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   src_valid;
  pkt_t [3:0]   src_pkt;
  logic [3:0]   src_ready;
  logic [3:0]   dst_valid;
  pkt_t [3:0]   dst_pkt;
  logic [3:0]   dst_ready;
  logic         rin_valid;
  logic         rin_ready;
  pkt_t         rin_pkt;
  logic         rout_valid;
  logic         rout_ready;
  pkt_t         rout_pkt;
  logic [15:0]  conflict_cnt;

  int n_chk = 0;
  int n_bad = 0;

  pkt_t r0, r1, r2;

  bank_xbar_arbiter #(.N(4), .BANK_ID(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_pkt(src_pkt), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_pkt(dst_pkt), .dst_ready(dst_ready),
    .rin_valid(rin_valid), .rin_ready(rin_ready), .rin_pkt(rin_pkt),
    .rout_valid(rout_valid), .rout_ready(rout_ready), .rout_pkt(rout_pkt),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic pkt_t mk(input logic [3:0] b, input logic [1:0] z, input logic [7:0] d);
    pkt_t p;
    p.addr.bank = b;
    p.addr.z    = z;
    p.data      = d;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b0;
    src_valid = '0; src_pkt = '0; dst_ready = '0;
    rin_valid = 1'b0; rin_pkt = '0; rout_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // reset state, then hold idle
    settle();
    chk("rst_src_ready", src_ready, 4'b0000);
    chk("rst_dst_valid", dst_valid, 4'b0000);
    chk("rst_dst_pkt", dst_pkt, 0);
    chk("rst_rin_ready", rin_ready, 1'b0);
    chk("rst_rout_valid", rout_valid, 1'b0);
    chk("rst_rout_pkt", rout_pkt, 0);
    chk("rst_cnt", conflict_cnt, 16'd0);
    chk("rst_ptr", dut.ptr, 2'd0);
    repeat (10) tick();
    settle();
    chk("idle_rout_valid", rout_valid, 1'b0);
    chk("idle_cnt", conflict_cnt, 16'd0);
    chk("idle_dst_valid", dst_valid, 4'b0000);
    chk("idle_ptr", dut.ptr, 2'd0);

    // ingress beats a local node for z=2
    tick();
    dst_ready = 4'b1111;
    rin_valid = 1'b1; rin_pkt = mk(4'd0, 2'd2, 8'hA5);
    src_valid = 4'b0010; src_pkt[1] = mk(4'd0, 2'd2, 8'h11);
    settle();
    chk("ing_rin_ready", rin_ready, 1'b1);
    chk("ing_dst_valid", dst_valid, 4'b0100);
    chk("ing_dst_pkt2", dst_pkt[2], mk(4'd0, 2'd2, 8'hA5));
    chk("ing_src_ready", src_ready, 4'b0000);
    tick();
    rin_valid = 1'b0; src_valid = '0;
    settle();
    chk("ing_cnt", conflict_cnt, 16'd1);
    chk("ing_ptr", dut.ptr, 2'd0);

    // four nodes contend for z=0: round-robin rotation
    for (int i = 0; i < 4; i++) src_pkt[i] = mk(4'd0, 2'd0, 8'h20 + 8'(i));
    src_valid = 4'b1111;
    settle();
    chk("rr0_src_ready", src_ready, 4'b0001);
    chk("rr0_dst_pkt0", dst_pkt[0], mk(4'd0, 2'd0, 8'h20));
    tick(); settle();
    chk("rr1_src_ready", src_ready, 4'b0010);
    tick(); settle();
    chk("rr2_src_ready", src_ready, 4'b0100);
    tick(); settle();
    chk("rr3_src_ready", src_ready, 4'b1000);
    chk("rr3_dst_pkt0", dst_pkt[0], mk(4'd0, 2'd0, 8'h23));
    tick();
    src_valid = '0;
    settle();
    chk("rr_ptr_wrap", dut.ptr, 2'd0);
    chk("rr_cnt", conflict_cnt, 16'd5);

    // move ptr to 2, then a fully conflict-free permutation
    src_valid = 4'b0010; src_pkt[1] = mk(4'd0, 2'd1, 8'h31);
    settle();
    chk("pre_src_ready", src_ready, 4'b0010);
    tick();
    for (int i = 0; i < 4; i++) src_pkt[i] = mk(4'd0, 2'(3 - i), 8'h40 + 8'(i));
    src_valid = 4'b1111;
    settle();
    chk("perm_ptr_before", dut.ptr, 2'd2);
    chk("perm_src_ready", src_ready, 4'b1111);
    chk("perm_dst_valid", dst_valid, 4'b1111);
    chk("perm_dst_pkt3", dst_pkt[3], mk(4'd0, 2'd3, 8'h40));
    chk("perm_dst_pkt0", dst_pkt[0], mk(4'd0, 2'd0, 8'h43));
    tick();
    src_valid = '0;
    settle();
    chk("perm_ptr_after", dut.ptr, 2'd2);
    chk("perm_cnt", conflict_cnt, 16'd5);

    // remote packets through the egress FIFO with router stalled
    r0 = mk(4'd1, 2'd0, 8'h50); r1 = mk(4'd2, 2'd1, 8'h51); r2 = mk(4'd3, 2'd2, 8'h52);
    src_pkt[0] = r0; src_pkt[1] = r1; src_pkt[2] = r2;
    src_valid = 4'b0011;
    settle();
    chk("rem1_src_ready", src_ready, 4'b0001);
    chk("rem1_rout_valid", rout_valid, 1'b0);
    tick();
    src_valid = 4'b0010;
    settle();
    chk("rem2_src_ready", src_ready, 4'b0010);
    chk("rem2_rout_valid", rout_valid, 1'b1);
    chk("rem2_rout_pkt", rout_pkt, r0);
    tick();
    src_valid = 4'b0100;
    settle();
    chk("full_src_ready", src_ready, 4'b0000);
    chk("full_rout_pkt", rout_pkt, r0);
    tick();
    rout_ready = 1'b1;
    settle();
    chk("pop0_src_ready", src_ready, 4'b0100);
    chk("pop0_rout_pkt", rout_pkt, r0);
    tick();
    src_valid = '0;
    settle();
    chk("pop1_rout_pkt", rout_pkt, r1);
    tick(); settle();
    chk("pop2_rout_pkt", rout_pkt, r2);
    tick(); settle();
    chk("drain_rout_valid", rout_valid, 1'b0);
    chk("drain_rout_pkt", rout_pkt, 0);
    chk("rem_cnt", conflict_cnt, 16'd7);
    rout_ready = 1'b0;

    // fill FIFO again, then hold an ingress conflict until saturation
    src_valid = 4'b0001;
    tick();
    src_valid = 4'b0010;
    tick();
    src_valid = '0;
    dst_ready = 4'b0000;
    rin_valid = 1'b1; rin_pkt = mk(4'd0, 2'd0, 8'h60);
    settle();
    chk("sat_rin_ready", rin_ready, 1'b0);
    repeat (65527) tick();
    settle();
    chk("sat_below", conflict_cnt, 16'hFFFE);
    tick(); settle();
    chk("sat_reach", conflict_cnt, 16'hFFFF);
    repeat (5) tick();
    settle();
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    chk("sat_rout_valid", rout_valid, 1'b1);
    chk("sat_rout_pkt", rout_pkt, r0);

    // asynchronous reset mid-burst
    rst = 1'b0;
    #1;
    chk("arst_rout_valid", rout_valid, 1'b0);
    chk("arst_rout_pkt", rout_pkt, 0);
    chk("arst_cnt", conflict_cnt, 16'd0);
    rin_valid = 1'b0; dst_ready = 4'b1111;
    tick();
    rst = 1'b1;
    tick(); settle();
    chk("post_rout_valid", rout_valid, 1'b0);
    chk("post_cnt", conflict_cnt, 16'd0);
    chk("post_ptr", dut.ptr, 2'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/bank_xbar_arbiter.md
# bank_xbar_arbiter

Per-bank crossbar arbiter that sits between a bank's node array and the mesh router. Each cycle it grants a conflict-free set of transfers to the node inputs: the router-ingress packet and node output packets addressed to this bank. Node packets addressed to other banks go into a 2-entry egress FIFO that drives the router. A registered round-robin pointer keeps node service fair, and a saturating counter records arbitration losses.

## Interface
Parameters:
- N, default NODES_PER_BANK: number of nodes in the bank.
- BANK_ID, default 0: this bank's id, compared against pkt_t addr.bank.
- CNT_W, default 16: width of the conflict counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- src_valid  in  N  node i has an output packet
- src_pkt  in  N x pkt_t  node output packets
- src_ready  out  N  node i's packet is consumed this cycle (grant)
- dst_valid  out  N  packet delivered to node i input
- dst_pkt  out  N x pkt_t  packet for node i input
- dst_ready  in  N  node i input can accept
- rin_valid  in  1  router ingress packet valid (always local, addr.bank == BANK_ID)
- rin_ready  out  1  ingress accepted
- rin_pkt  in  pkt_t  ingress packet
- rout_valid  out  1  egress FIFO non-empty
- rout_ready  in  1  router accepts egress head
- rout_pkt  out  pkt_t  egress FIFO head
- conflict_cnt  out  CNT_W  cycles in which at least one valid source was not granted

## Operation
- Arbitration is combinational over the current inputs and registered state. It uses a per-cycle claim vector claimed[N] and a flag egress_claimed.
- Step 1, ingress, with absolute priority:
  - rin_ready = dst_ready[rin_pkt.addr.z]. This does not depend on rin_valid.
  - If rin_valid && rin_ready: drive dst_valid/dst_pkt[z] from rin_pkt and set claimed[z].
- Step 2, nodes: scan k = 0..N-1 with idx = (ptr + k) mod N. Skip any idx where src_valid is 0.
  - Local packet (addr.bank == BANK_ID), z = addr.z: grant iff !claimed[z] && dst_ready[z]. On grant, drive dst[z], set claimed[z], and set src_ready[idx].
  - Remote packet: grant iff !egress_claimed && fifo_space. On grant, push it to the FIFO and set egress_claimed and src_ready[idx].
  - A loser never blocks later indices. There is no early break.
- fifo_space = (count < 2) || (rout_valid && rout_ready). A push and a pop when full occur in the same cycle.
- Pointer update: ptr_next = (last granted idx in scan order + 1) mod N. If no node was granted, ptr is unchanged.
- The pointer width is $clog2(N) bits (1 bit if N == 1). The mod-N wrap is explicit and does not rely on natural overflow.
- Egress FIFO:
  - 2 entries, in-order.
  - Pop when rout_valid && rout_ready.
  - When empty, rout_pkt = '0.
- conflict_cnt increments when (src_valid & ~src_ready) != 0 or (rin_valid && !rin_ready). It saturates at all-ones and does not wrap.
- Unselected dst_pkt entries and rout_pkt when empty are driven to '0. Outputs have no X on any lane.

## Timing
- Reset (rst == 0, asynchronous):
  - ptr = 0, FIFO count = 0, conflict_cnt = 0.
  - rout_valid = 0, rout_pkt = '0.
  - Combinational outputs follow inputs but see empty state.
  - Reset asserted mid-transfer discards FIFO contents. Nothing is replayed.
- Local delivery: 0-cycle latency. src_ready, dst_valid and rin_ready are valid in the same cycle as the request.
- Remote: a packet granted in cycle t appears on rout_pkt with rout_valid = 1 at cycle t+1 at the earliest.
- Handshakes:
  - A node or the router must hold valid/pkt stable until ready.
  - The block never drops a granted packet.
- Throughput:
  - Up to min(N, distinct local z) + 1 remote grants per cycle.
  - Sustained egress is 1 packet per cycle when rout_ready is held at 1.
- Full FIFO with rout_ready = 0: all remote requests lose, and they count as conflicts.

## Test plan
(N = 4, BANK_ID = 0)
- Reset release with all inputs at 0 → all outputs 0, ptr = 0, conflict_cnt = 0. Hold for 10 cycles: no change.
- rin_valid with z = 2, and node 1 local to z = 2 → dst[2] = rin_pkt, rin_ready = 1, src_ready = 0000, conflict_cnt increments by 1.
- All 4 nodes valid to z = 0, all dst_ready = 1, held for 4 cycles → grants rotate 0, 1, 2, 3 (src_ready = 0001, 0010, 0100, 1000). ptr returns to 0.
- Nodes 0..3 to z = 3, 2, 1, 0 with ptr = 2 → all four granted in one cycle, src_ready = 1111, ptr_next = 2 (last scanned idx 1, plus 1).
- Nodes 0 and 1 both remote, rout_ready = 0:
  - Cycle 1: node 0 pushed. Cycle 2: node 1 pushed. FIFO count = 2.
  - Cycle 3: new remote from node 2 → src_ready[2] = 0.
  - Raise rout_ready → pops in order 0, 1, with node 2 pushed in the same cycle as the first pop.
- Pre-load conflict_cnt near all-ones by holding a conflict for 2^CNT_W + 5 cycles → counter saturates at 0xFFFF. Assert rst low mid-burst with FIFO count = 2 → rout_valid = 0 immediately, without waiting for a clock edge.
